traffic_ctrl_core: RTL and testbench
====================================

# traffic_ctrl_core

Core of the labkit traffic-light controller. It debounces and synchronizes the three raw pushbutton/switch inputs and divides the system clock into a 1 Hz enable. It runs the light-sequencing FSM, which drives the 7 light outputs and commands the external interval timer. Timer, time-parameter store and walk register sit outside this block and connect through the ports below.

## Interface
- Clocking: one clock; reset is synchronous and active-high.
- Parameters:
  - DEB_DELAY, 16: consecutive stable cycles required before a debounced output changes.
  - DIV_COUNT, 27000000: clk cycles per one_hz_enable pulse; must be ≥ 2.
- Ports:
  - clk  in  1  system clock.
  - g_reset  in  1  synchronous active-high reset.
  - sensor_in  in  1  raw side-street vehicle sensor.
  - walk_in  in  1  raw walk button.
  - reprogram_in  in  1  raw reprogram button.
  - expired  in  1  timer expiry pulse.
  - WR_Out  in  1  walk request pending, from the walk register.
  - sensor_sync  out  1  debounced sensor.
  - WR_Sync  out  1  debounced walk button, to the walk register.
  - prog_sync  out  1  debounced reprogram.
  - one_hz_enable  out  1  1-cycle tick every DIV_COUNT cycles.
  - start_timer  out  1  timer (re)start pulse.
  - interval  out  2  timer interval select: 00 tBASE, 01 tEXT, 10 tYEL; 11 is never driven.
  - WR_Reset  out  1  clears the walk register.
  - lights  out  7  {main_R, main_Y, main_G, side_R, side_Y, side_G, walk}, bits 6..0.

## Operation
- Debounce, applied to each raw input:
  - Two-flop synchronizer, then a stability counter.
  - Output takes the synchronized value after DEB_DELAY consecutive cycles at a value differing from the output.
  - Any change in the synchronized value restarts the count.
- Divider: counter runs 0..DIV_COUNT-1 and wraps. one_hz_enable = 1 exactly when counter == DIV_COUNT-1.
- FSM states, with interval and lights:
  - MAIN_G1: tBASE, 0011000.
  - MAIN_G2: tBASE, 0011000.
  - MAIN_Y: tYEL, 0101000.
  - WALK: tEXT, 1001001.
  - SIDE_G1: tBASE, 1000010.
  - SIDE_G2: tEXT, 1000010.
  - SIDE_Y: tYEL, 1000100.
- Transitions occur only on expired. sensor_sync and WR_Out are sampled in the expired cycle.
  - MAIN_G1 → MAIN_Y if sensor_sync, else MAIN_G2.
  - MAIN_G2 → MAIN_Y.
  - MAIN_Y → WALK if WR_Out, else SIDE_G1.
  - WALK → SIDE_G1.
  - SIDE_G1 → SIDE_G2 if sensor_sync, else SIDE_Y.
  - SIDE_G2 → SIDE_Y.
  - SIDE_Y → MAIN_G1.
- start_timer pulses for 1 cycle on the first cycle in every new state.
- interval is valid in that same cycle and held constant for the whole state.
- WR_Reset pulses for 1 cycle on entry to WALK, coincident with start_timer.
- prog_sync high: FSM is forced to MAIN_G1 and start_timer = 1 every cycle. When prog_sync falls, the state stays MAIN_G1 with no extra pulse; the timer was restarted on the last prog_sync cycle.
- Priority: g_reset > prog_sync > expired.

## Timing
- Reset values:
  - All outputs: sensor_sync/WR_Sync/prog_sync 0, debounce counters 0, divider counter 0, one_hz_enable 0, state MAIN_G1, lights 0011000, interval 00, start_timer 0, WR_Reset 0.
  - First cycle after g_reset deasserts: start_timer = 1 (MAIN_G1 entry).
- Debounce latency: raw edge → output change = 2 + DEB_DELAY cycles. A glitch shorter than DEB_DELAY cycles produces no output change.
- Divider: first tick DIV_COUNT cycles after reset release, then periodic.
- FSM latency: expired in cycle n → new state, lights, interval and start_timer in cycle n+1.
  - expired in the same cycle as start_timer is ignored.
  - expired is a no-op while prog_sync is high.
- Reset mid-state: return to MAIN_G1 next edge. A pending WR_Reset or start_timer pulse is cancelled.

## Structure
- Shared package holds:
  - state enum: MAIN_G1, MAIN_G2, MAIN_Y, WALK, SIDE_G1, SIDE_G2, SIDE_Y;
  - interval codes: T_BASE = 2'b00, T_EXT = 2'b01, T_YEL = 2'b10;
  - 7-bit light constants.
- Sub-modules:
  - debounce, instantiated 3 times;
  - divider.
- The FSM lives in the top level.

## Test plan
- **Reset:** pulse g_reset for 3 cycles → lights = 0011000, interval = 00. start_timer = 1 only on the first cycle after release.
- **Normal cycle, no sensor, WR_Out = 0:** pulse expired after each start → states visit MAIN_G1, MAIN_G2, MAIN_Y, SIDE_G1, SIDE_Y, MAIN_G1 with intervals 00, 00, 10, 00, 10.
- **Sensor = 1 throughout:** sequence MAIN_G1 → MAIN_Y → SIDE_G1 → SIDE_G2 (interval 01) → SIDE_Y.
- **Walk:** WR_Out = 1 at MAIN_Y expiry → lights = 1001001, interval = 01, WR_Reset = 1 for exactly 1 cycle, then SIDE_G1.
- **Debounce (DEB_DELAY = 16):** 5-cycle glitch on sensor_in → sensor_sync stays 0. Steady high → sensor_sync = 1 after 18 cycles.
- **Divider and reprogram:**
  - DIV_COUNT = 4 → one_hz_enable high on every 4th cycle.
  - prog_sync asserted in SIDE_G1 → next cycle MAIN_G1 with start_timer held 1 while prog_sync is high.

Source files
------------

// File: rtl/traffic_ctrl_core_pkg.sv
// Shared types and constants for the traffic-light controller core:
// state encodings, timer interval codes, light patterns and decode helpers.
package traffic_ctrl_core_pkg;

   typedef logic [2:0] state_t;

   // State encoding; values are fixed so external tools decoding state stay valid.
   localparam state_t MAIN_G1 = 3'd0;
   localparam state_t MAIN_G2 = 3'd1;
   localparam state_t MAIN_Y  = 3'd2;
   localparam state_t WALK    = 3'd3;
   localparam state_t SIDE_G1 = 3'd4;
   localparam state_t SIDE_G2 = 3'd5;
   localparam state_t SIDE_Y  = 3'd6;

   // Timer interval select codes.
   localparam logic [1:0] T_BASE = 2'b00;
   localparam logic [1:0] T_EXT  = 2'b01;
   localparam logic [1:0] T_YEL  = 2'b10;

   // Light patterns {main_R, main_Y, main_G, side_R, side_Y, side_G, walk}.
   localparam logic [6:0] L_MAIN_G = 7'b0011000;
   localparam logic [6:0] L_MAIN_Y = 7'b0101000;
   localparam logic [6:0] L_WALK   = 7'b1001001;
   localparam logic [6:0] L_SIDE_G = 7'b1000010;
   localparam logic [6:0] L_SIDE_Y = 7'b1000100;

   function automatic logic [6:0] state_lights(state_t s);
      case (s)
         MAIN_Y:           return L_MAIN_Y;
         WALK:             return L_WALK;
         SIDE_G1, SIDE_G2: return L_SIDE_G;
         SIDE_Y:           return L_SIDE_Y;
         default:          return L_MAIN_G;
      endcase
   endfunction

   function automatic logic [1:0] state_interval(state_t s);
      case (s)
         MAIN_Y, SIDE_Y: return T_YEL;
         WALK, SIDE_G2:  return T_EXT;
         default:        return T_BASE;
      endcase
   endfunction

endpackage

// File: rtl/traffic_ctrl_core_if.sv
// Timer / walk-register link of the traffic controller core.
// master = the core, slave = external interval timer and walk register.
interface traffic_ctrl_core_if;
   logic       expired;
   logic       WR_Out;
   logic       start_timer;
   logic [1:0] interval;
   logic       WR_Reset;

   modport master (input expired, input WR_Out,
                   output start_timer, output interval, output WR_Reset);
   modport slave  (output expired, output WR_Out,
                   input start_timer, input interval, input WR_Reset);
endinterface

// File: rtl/traffic_ctrl_core_debounce.sv
// Two-flop synchronizer followed by a stability counter. The output only
// follows the synchronized input after DEB_DELAY consecutive cycles at a
// value different from the current output.
module traffic_ctrl_core_debounce #(
   parameter int DEB_DELAY = 16
) (
   input  logic clk,
   input  logic g_reset,
   input  logic raw,
   output logic clean
);
   localparam int CW = (DEB_DELAY > 1) ? $clog2(DEB_DELAY) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEB_DELAY - 1);

   logic          s1, s2;
   logic [CW-1:0] cnt;

   // Synchronize, then count cycles the synchronized value disagrees with the output.
   // A return to agreement (any change of s2 while counting) restarts the count.
   always_ff @(posedge clk) begin
      if (g_reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         clean <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == clean) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt   <= '0;
            clean <= s2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/traffic_ctrl_core_divider.sv
// Free-running modulo-DIV_COUNT counter producing a one-cycle enable on
// its terminal count.
module traffic_ctrl_core_divider #(
   parameter int DIV_COUNT = 27000000
) (
   input  logic clk,
   input  logic g_reset,
   output logic one_hz_enable
);
   localparam int CW = $clog2(DIV_COUNT);
   localparam logic [CW-1:0] LAST = CW'(DIV_COUNT - 1);

   logic [CW-1:0] cnt;

   // Count 0..DIV_COUNT-1 and wrap.
   always_ff @(posedge clk) begin
      if (g_reset)         cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
   end

   assign one_hz_enable = (cnt == LAST);
endmodule

// File: rtl/traffic_ctrl_core.sv
// Traffic-light controller core: input debouncing, 1 Hz divider and the
// light-sequencing FSM that drives the lights and commands the interval timer.
module traffic_ctrl_core
   import traffic_ctrl_core_pkg::*;
#(
   parameter int DEB_DELAY = 16,
   parameter int DIV_COUNT = 27000000
) (
   input  logic                clk,
   input  logic                g_reset,
   input  logic                sensor_in,
   input  logic                walk_in,
   input  logic                reprogram_in,
   traffic_ctrl_core_if.master tmr,
   output logic                sensor_sync,
   output logic                WR_Sync,
   output logic                prog_sync,
   output logic                one_hz_enable,
   output logic [6:0]          lights
);
   localparam int NUM_IN = 3;

   logic [NUM_IN-1:0] raw, clean;
   state_t            state, nxt;
   logic              entry;      // first cycle of the current state
   logic              walk_entry; // first cycle of WALK

   assign raw = {reprogram_in, walk_in, sensor_in};

   for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
      traffic_ctrl_core_debounce #(.DEB_DELAY(DEB_DELAY)) u_deb (
         .clk     (clk),
         .g_reset (g_reset),
         .raw     (raw[i]),
         .clean   (clean[i])
      );
   end

   assign {prog_sync, WR_Sync, sensor_sync} = clean;

   traffic_ctrl_core_divider #(.DIV_COUNT(DIV_COUNT)) u_div (
      .clk           (clk),
      .g_reset       (g_reset),
      .one_hz_enable (one_hz_enable)
   );

   // Successor state taken when the timer expires.
   always_comb begin
      nxt = MAIN_G1;
      case (state)
         MAIN_G1: nxt = sensor_sync ? MAIN_Y : MAIN_G2;
         MAIN_G2: nxt = MAIN_Y;
         MAIN_Y:  nxt = tmr.WR_Out ? WALK : SIDE_G1;
         WALK:    nxt = SIDE_G1;
         SIDE_G1: nxt = sensor_sync ? SIDE_G2 : SIDE_Y;
         SIDE_G2: nxt = SIDE_Y;
         default: nxt = MAIN_G1;
      endcase
   end

   // State register. Reset re-enters MAIN_G1 so its start pulse follows release;
   // reprogram parks in MAIN_G1 without an entry pulse since start_timer is
   // already held by prog_sync. Expiry coinciding with an entry is ignored.
   always_ff @(posedge clk) begin
      if (g_reset) begin
         state      <= MAIN_G1;
         entry      <= 1'b1;
         walk_entry <= 1'b0;
      end else if (prog_sync) begin
         state      <= MAIN_G1;
         entry      <= 1'b0;
         walk_entry <= 1'b0;
      end else if (tmr.expired && !entry) begin
         state      <= nxt;
         entry      <= 1'b1;
         walk_entry <= (nxt == WALK);
      end else begin
         entry      <= 1'b0;
         walk_entry <= 1'b0;
      end
   end

   // Reset gates the pulses combinationally so a pending one never escapes.
   assign tmr.start_timer = !g_reset && (entry || prog_sync);
   assign tmr.WR_Reset    = !g_reset && walk_entry;
   assign tmr.interval    = state_interval(state);
   assign lights          = state_lights(state);

endmodule

// File: tb/tb_traffic_ctrl_core.sv
// Self-checking bench for traffic_ctrl_core: reset, divider, FSM sequences
// driven from a vector table through a scoreboard queue, debounce, reprogram.
module tb_traffic_ctrl_core;
   localparam logic [6:0] MG = 7'b0011000;
   localparam logic [6:0] MY = 7'b0101000;
   localparam logic [6:0] WK = 7'b1001001;
   localparam logic [6:0] SG = 7'b1000010;
   localparam logic [6:0] SY = 7'b1000100;

   logic clk = 1'b0;
   logic g_reset, sensor_in, walk_in, reprogram_in;
   logic sensor_sync, WR_Sync, prog_sync, one_hz_enable;
   logic [6:0] lights;

   traffic_ctrl_core_if tif();

   traffic_ctrl_core #(.DEB_DELAY(16), .DIV_COUNT(4)) dut (
      .clk           (clk),
      .g_reset       (g_reset),
      .sensor_in     (sensor_in),
      .walk_in       (walk_in),
      .reprogram_in  (reprogram_in),
      .tmr           (tif),
      .sensor_sync   (sensor_sync),
      .WR_Sync       (WR_Sync),
      .prog_sync     (prog_sync),
      .one_hz_enable (one_hz_enable),
      .lights        (lights)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       ex;
      logic       wr;
      logic [6:0] lt;
      logic [1:0] iv;
      logic       st;
      logic       wrr;
   } vec_t;

   typedef struct packed {
      logic [6:0] lt;
      logic [1:0] iv;
      logic       st;
      logic       wrr;
   } exp_t;

   vec_t vecs[32];
   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in the first cycle after reset release.
   task automatic do_reset();
      g_reset = 1'b1;
      tif.expired = 1'b0;
      tif.WR_Out = 1'b0;
      repeat (3) tick();
      g_reset = 1'b0;
      #1;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      exp_t e;
      for (int i = lo; i <= hi; i++) begin
         tif.expired = vecs[i].ex;
         tif.WR_Out  = vecs[i].wr;
         sb.push_back({vecs[i].lt, vecs[i].iv, vecs[i].st, vecs[i].wrr});
         tick();
         e = sb.pop_front();
         chk($sformatf("vec%0d lights", i), {1'b0, lights}, {1'b0, e.lt});
         chk($sformatf("vec%0d interval", i), {6'd0, tif.interval}, {6'd0, e.iv});
         chk($sformatf("vec%0d start", i), {7'd0, tif.start_timer}, {7'd0, e.st});
         chk($sformatf("vec%0d wr_reset", i), {7'd0, tif.WR_Reset}, {7'd0, e.wrr});
      end
      tif.expired = 1'b0;
      tif.WR_Out = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit glitch_seen;
      g_reset = 1'b1; sensor_in = 1'b0; walk_in = 1'b0; reprogram_in = 1'b0;
      tif.expired = 1'b0; tif.WR_Out = 1'b0;

      // Segment A: sensor low; normal cycle then walk cycle.
      //            ex    wr    lights iv     st    wrr
      vecs[0]  = '{1'b1, 1'b0, MG, 2'b00, 1'b0, 1'b0}; // expiry during start: ignored
      vecs[1]  = '{1'b0, 1'b0, MG, 2'b00, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, MG, 2'b00, 1'b1, 1'b0}; // MAIN_G2
      vecs[3]  = '{1'b0, 1'b0, MG, 2'b00, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, MY, 2'b10, 1'b1, 1'b0}; // MAIN_Y
      vecs[5]  = '{1'b0, 1'b0, MY, 2'b10, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, SG, 2'b00, 1'b1, 1'b0}; // SIDE_G1
      vecs[7]  = '{1'b0, 1'b0, SG, 2'b00, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, SY, 2'b10, 1'b1, 1'b0}; // SIDE_Y
      vecs[9]  = '{1'b0, 1'b0, SY, 2'b10, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, MG, 2'b00, 1'b1, 1'b0}; // MAIN_G1
      vecs[11] = '{1'b0, 1'b0, MG, 2'b00, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, MG, 2'b00, 1'b1, 1'b0}; // MAIN_G2
      vecs[13] = '{1'b0, 1'b0, MG, 2'b00, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, MY, 2'b10, 1'b1, 1'b0}; // MAIN_Y
      vecs[15] = '{1'b0, 1'b1, MY, 2'b10, 1'b0, 1'b0}; // WR_Out without expiry
      vecs[16] = '{1'b1, 1'b1, WK, 2'b01, 1'b1, 1'b1}; // WALK
      vecs[17] = '{1'b0, 1'b1, WK, 2'b01, 1'b0, 1'b0};
      vecs[18] = '{1'b1, 1'b0, SG, 2'b00, 1'b1, 1'b0}; // SIDE_G1
      vecs[19] = '{1'b0, 1'b0, SG, 2'b00, 1'b0, 1'b0};
      vecs[20] = '{1'b1, 1'b0, SY, 2'b10, 1'b1, 1'b0}; // SIDE_Y
      vecs[21] = '{1'b1, 1'b0, SY, 2'b10, 1'b0, 1'b0}; // expiry during start: ignored
      vecs[22] = '{1'b1, 1'b0, MG, 2'b00, 1'b1, 1'b0}; // MAIN_G1
      // Segment B: sensor high, starting in MAIN_G1 after its start pulse.
      vecs[23] = '{1'b1, 1'b0, MY, 2'b10, 1'b1, 1'b0}; // MAIN_Y
      vecs[24] = '{1'b0, 1'b0, MY, 2'b10, 1'b0, 1'b0};
      vecs[25] = '{1'b1, 1'b0, SG, 2'b00, 1'b1, 1'b0}; // SIDE_G1
      vecs[26] = '{1'b0, 1'b0, SG, 2'b00, 1'b0, 1'b0};
      vecs[27] = '{1'b1, 1'b0, SG, 2'b01, 1'b1, 1'b0}; // SIDE_G2
      vecs[28] = '{1'b0, 1'b0, SG, 2'b01, 1'b0, 1'b0};
      vecs[29] = '{1'b1, 1'b0, SY, 2'b10, 1'b1, 1'b0}; // SIDE_Y
      vecs[30] = '{1'b0, 1'b0, SY, 2'b10, 1'b0, 1'b0};
      vecs[31] = '{1'b1, 1'b0, MG, 2'b00, 1'b1, 1'b0}; // MAIN_G1

      // Reset values, checked while reset is held.
      repeat (3) tick();
      chk("rst lights", {1'b0, lights}, {1'b0, MG});
      chk("rst interval", {6'd0, tif.interval}, 8'd0);
      chk("rst start", {7'd0, tif.start_timer}, 8'd0);
      chk("rst wr_reset", {7'd0, tif.WR_Reset}, 8'd0);
      chk("rst syncs", {5'd0, prog_sync, WR_Sync, sensor_sync}, 8'd0);
      chk("rst one_hz", {7'd0, one_hz_enable}, 8'd0);

      // Release: start pulse in cycle 1 only; divider ticks every 4th cycle.
      g_reset = 1'b0;
      #1;
      for (int c = 1; c <= 12; c++) begin
         chk($sformatf("div c%0d", c), {7'd0, one_hz_enable}, {7'd0, (c % 4 == 0)});
         chk($sformatf("rel start c%0d", c), {7'd0, tif.start_timer}, {7'd0, (c == 1)});
         tick();
      end

      // Table-driven FSM sequences.
      do_reset();
      run_vecs(0, 22);

      // Reset in the WALK entry cycle cancels the pending pulses.
      do_reset();
      run_vecs(0, 16);
      g_reset = 1'b1;
      #1;
      chk("midrst wr_reset", {7'd0, tif.WR_Reset}, 8'd0);
      chk("midrst start", {7'd0, tif.start_timer}, 8'd0);
      tick();
      chk("midrst lights", {1'b0, lights}, {1'b0, MG});
      chk("midrst interval", {6'd0, tif.interval}, 8'd0);

      // Sensor held high: wait for the debounced level, then run segment B.
      sensor_in = 1'b1;
      do_reset();
      repeat (20) tick();
      chk("sensor_sync steady", {7'd0, sensor_sync}, 8'd1);
      run_vecs(23, 31);

      // Debounce: 5-cycle glitch is rejected; steady level passes after 18 edges.
      sensor_in = 1'b0;
      do_reset();
      repeat (20) tick();
      sensor_in = 1'b1;
      repeat (5) tick();
      sensor_in = 1'b0;
      glitch_seen = 1'b0;
      for (int c = 0; c < 25; c++) begin
         if (sensor_sync) glitch_seen = 1'b1;
         tick();
      end
      chk("glitch rejected", {7'd0, glitch_seen}, 8'd0);
      sensor_in = 1'b1;
      walk_in = 1'b1;
      repeat (17) tick();
      chk("deb edge17 sensor", {7'd0, sensor_sync}, 8'd0);
      chk("deb edge17 walk", {7'd0, WR_Sync}, 8'd0);
      tick();
      chk("deb edge18 sensor", {7'd0, sensor_sync}, 8'd1);
      chk("deb edge18 walk", {7'd0, WR_Sync}, 8'd1);
      sensor_in = 1'b0;
      walk_in = 1'b0;
      repeat (17) tick();
      chk("deb fall17", {7'd0, sensor_sync}, 8'd1);
      tick();
      chk("deb fall18", {7'd0, sensor_sync}, 8'd0);

      // Reprogram from SIDE_G1 (sensor low).
      do_reset();
      tick();
      tif.expired = 1'b1; tick(); tif.expired = 1'b0; tick(); // MAIN_G2
      tif.expired = 1'b1; tick(); tif.expired = 1'b0; tick(); // MAIN_Y
      tif.expired = 1'b1; tick(); tif.expired = 1'b0; tick(); // SIDE_G1
      chk("prog pre lights", {1'b0, lights}, {1'b0, SG});
      reprogram_in = 1'b1;
      repeat (17) tick();
      chk("prog rise17", {7'd0, prog_sync}, 8'd0);
      chk("prog rise17 start", {7'd0, tif.start_timer}, 8'd0);
      tick();
      chk("prog rise18", {7'd0, prog_sync}, 8'd1);
      chk("prog rise18 start", {7'd0, tif.start_timer}, 8'd1);
      tick();
      chk("prog forced lights", {1'b0, lights}, {1'b0, MG});
      chk("prog forced start", {7'd0, tif.start_timer}, 8'd1);
      tif.expired = 1'b1;
      repeat (3) tick();
      chk("prog expired noop lights", {1'b0, lights}, {1'b0, MG});
      chk("prog expired noop iv", {6'd0, tif.interval}, 8'd0);
      chk("prog held start", {7'd0, tif.start_timer}, 8'd1);
      tif.expired = 1'b0;
      reprogram_in = 1'b0;
      repeat (17) tick();
      chk("prog fall17 start", {7'd0, tif.start_timer}, 8'd1);
      tick();
      chk("prog fall18", {7'd0, prog_sync}, 8'd0);
      chk("prog fall no pulse", {7'd0, tif.start_timer}, 8'd0);
      chk("prog fall lights", {1'b0, lights}, {1'b0, MG});
      tif.expired = 1'b1; tick(); tif.expired = 1'b0;
      chk("post prog start", {7'd0, tif.start_timer}, 8'd1);
      tick();
      tif.expired = 1'b1; tick(); tif.expired = 1'b0;
      chk("post prog G2->Y", {1'b0, lights}, {1'b0, MY});

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
